// File: rtl/ffn_mac_engine_if.sv
// Control handshake plus feature-map/weight read-port bundle for ffn_mac_engine.
// The engine side uses the master modport; the RAM/control side uses slave.
interface ffn_mac_engine_if #(
    parameter int unsigned NUM_CH      = 2,
    parameter int unsigned FM_DEPTH    = 1024,
    parameter int unsigned NUM_CLASSES = 2,
    parameter int unsigned IN_W        = 18,
    parameter int unsigned W_W         = 18,
    parameter int unsigned ACC_W       = 48
);
    localparam int unsigned AW  = (FM_DEPTH > 1) ? $clog2(FM_DEPTH) : 1;
    localparam int unsigned CW  = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;
    localparam int unsigned WAW = (NUM_CH * FM_DEPTH > 1) ? $clog2(NUM_CH * FM_DEPTH) : 1;
    localparam int unsigned CLW = (NUM_CLASSES > 1) ? $clog2(NUM_CLASSES) : 1;

    logic                           start;
    logic [AW-1:0]                  fm_rd_addr;
    logic [CW-1:0]                  ch_sel;
    logic [IN_W-1:0]                fm_rd_data;
    logic [WAW-1:0]                 w_rd_addr;
    logic [NUM_CLASSES*W_W-1:0]     w_rd_data;
    logic                           busy;
    logic                           result_valid;
    logic [NUM_CLASSES*ACC_W-1:0]   sums;
    logic [CLW-1:0]                 class_idx;

    modport master (
        input  start, fm_rd_data, w_rd_data,
        output fm_rd_addr, ch_sel, w_rd_addr, busy, result_valid, sums, class_idx
    );

    modport slave (
        output start, fm_rd_data, w_rd_data,
        input  fm_rd_addr, ch_sel, w_rd_addr, busy, result_valid, sums, class_idx
    );
endinterface

// File: rtl/ffn_mac_engine.sv
// Streams all feature-map words across NUM_CH buffers, accumulates NUM_CLASSES
// dot products against per-class weights, then registers the sums and their argmax.
module ffn_mac_engine #(
    parameter int unsigned NUM_CH      = 2,
    parameter int unsigned FM_DEPTH    = 1024,
    parameter int unsigned NUM_CLASSES = 2,
    parameter int unsigned IN_W        = 18,
    parameter int unsigned W_W         = 18,
    parameter int unsigned ACC_W       = 48,
    parameter int unsigned RD_LAT      = 2,
    parameter int unsigned SAT         = 1
) (
    input logic             clock,
    input logic             reset,
    ffn_mac_engine_if.master bus
);
    localparam int unsigned AW  = (FM_DEPTH > 1) ? $clog2(FM_DEPTH) : 1;
    localparam int unsigned CW  = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;
    localparam int unsigned WAW = (NUM_CH * FM_DEPTH > 1) ? $clog2(NUM_CH * FM_DEPTH) : 1;
    localparam int unsigned CLW = (NUM_CLASSES > 1) ? $clog2(NUM_CLASSES) : 1;
    localparam int unsigned PW  = IN_W + W_W + 1;
    localparam int unsigned SW  = ACC_W + 1;
    localparam int unsigned DCW = $clog2(RD_LAT + 2) + 1;
    localparam logic signed [ACC_W-1:0] ACC_MAX = {1'b0, {(ACC_W-1){1'b1}}};
    localparam logic signed [ACC_W-1:0] ACC_MIN = {1'b1, {(ACC_W-1){1'b0}}};

    typedef enum logic [1:0] {IDLE, ISSUE, DRAIN, DONE} state_t;

    state_t                  state, state_nx;
    logic                    accept;
    logic                    last_word;
    logic                    drain_last;
    logic [AW-1:0]           addr;
    logic [CW-1:0]           ch;
    logic [WAW-1:0]          waddr;
    logic [DCW-1:0]          drain_cnt;
    logic [RD_LAT:0]         vtag;
    logic signed [PW-1:0]    fm_ext;
    logic signed [PW-1:0]    prod_c   [NUM_CLASSES];
    logic signed [PW-1:0]    prod_q   [NUM_CLASSES];
    logic signed [SW-1:0]    sum_w    [NUM_CLASSES];
    logic signed [ACC_W-1:0] acc      [NUM_CLASSES];
    logic signed [ACC_W-1:0] acc_nx   [NUM_CLASSES];
    logic signed [ACC_W-1:0] best_val;
    logic [CLW-1:0]          best;

    assign accept     = bus.start && (state == IDLE || state == DONE);
    assign last_word  = (ch == CW'(NUM_CH - 1)) && (addr == AW'(FM_DEPTH - 1));
    assign drain_last = (drain_cnt == DCW'(RD_LAT + 1));

    assign bus.fm_rd_addr = addr;
    assign bus.ch_sel     = ch;
    assign bus.w_rd_addr  = waddr;

    always_ff @(posedge clock) begin
        if (!reset) begin
            state     <= IDLE;
            addr      <= '0;
            ch        <= '0;
            waddr     <= '0;
            drain_cnt <= '0;
        end else begin
            state <= state_nx;
            if (state == ISSUE && !last_word) begin
                waddr <= waddr + WAW'(1);
                if (addr == AW'(FM_DEPTH - 1)) begin
                    addr <= '0;
                    ch   <= ch + CW'(1);
                end else begin
                    addr <= addr + AW'(1);
                end
            end else begin
                addr  <= '0;
                ch    <= '0;
                waddr <= '0;
            end
            drain_cnt <= (state == DRAIN) ? drain_cnt + DCW'(1) : '0;
        end
    end

    always_comb begin
        state_nx         = state;
        bus.busy         = 1'b0;
        bus.result_valid = 1'b0;
        case (state)
            IDLE:  if (bus.start) state_nx = ISSUE;
            ISSUE: begin
                bus.busy = 1'b1;
                if (last_word) state_nx = DRAIN;
            end
            DRAIN: begin
                bus.busy = 1'b1;
                if (drain_last) state_nx = DONE;
            end
            DONE: begin
                bus.result_valid = 1'b1;
                state_nx = bus.start ? ISSUE : IDLE;
            end
            default: state_nx = IDLE;
        endcase
    end

    // Feature is unsigned: zero-extend before the signed multiply.
    always_comb begin
        fm_ext = PW'({1'b0, bus.fm_rd_data});
        for (int unsigned c = 0; c < NUM_CLASSES; c++) begin
            prod_c[c] = fm_ext * PW'($signed(bus.w_rd_data[c*W_W +: W_W]));
        end
    end

    always_comb begin
        for (int unsigned c = 0; c < NUM_CLASSES; c++) begin
            sum_w[c] = SW'(acc[c]) + SW'(ACC_W'(prod_q[c]));
            if (SAT != 0 && sum_w[c][ACC_W] != sum_w[c][ACC_W-1]) begin
                acc_nx[c] = sum_w[c][ACC_W] ? ACC_MIN : ACC_MAX;
            end else begin
                acc_nx[c] = sum_w[c][ACC_W-1:0];
            end
        end
    end

    // Strict greater-than keeps the lowest index on ties.
    always_comb begin
        best     = '0;
        best_val = acc[0];
        for (int unsigned c = 1; c < NUM_CLASSES; c++) begin
            if (acc[c] > best_val) begin
                best_val = acc[c];
                best     = CLW'(c);
            end
        end
    end

    // vtag[RD_LAT-1] marks read data arriving, vtag[RD_LAT] the registered product.
    always_ff @(posedge clock) begin
        if (!reset || accept) begin
            vtag          <= '0;
            bus.sums      <= '0;
            bus.class_idx <= '0;
            for (int unsigned c = 0; c < NUM_CLASSES; c++) begin
                prod_q[c] <= '0;
                acc[c]    <= '0;
            end
        end else begin
            vtag <= {vtag[RD_LAT-1:0], state == ISSUE};
            for (int unsigned c = 0; c < NUM_CLASSES; c++) begin
                prod_q[c] <= prod_c[c];
                if (vtag[RD_LAT]) acc[c] <= acc_nx[c];
            end
            if (state == DRAIN && drain_last) begin
                for (int unsigned c = 0; c < NUM_CLASSES; c++) begin
                    bus.sums[c*ACC_W +: ACC_W] <= acc[c];
                end
                bus.class_idx <= best;
            end
        end
    end
endmodule
